// File: rtl/stopwatch_pkg.sv
// Shared encodings for the mm:ss stopwatch controller.
package stopwatch_pkg;

   localparam int DIGIT_W = 4;
   localparam int DISP_W  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      LAP   = 2'd3
   } state_t;

endpackage

// File: rtl/stopwatch_if.sv
// Signal bundle between the stopwatch controller, the board keys and the
// BCD counter / display path.
// Protocol: keys are raw asynchronous levels (low = pressed); cnt_en and
// cnt_clr are single-cycle strobes that the counter acts on at the next
// posedge with no back-pressure; disp_bcd, state, lap_active and key_level
// are plain levels valid every cycle.
interface stopwatch_if;
   import stopwatch_pkg::*;

   logic              key_start_n;
   logic              key_lap_n;
   logic              key_clear_n;
   logic [DISP_W-1:0] time_bcd;
   logic              cnt_en;
   logic              cnt_clr;
   logic [DISP_W-1:0] disp_bcd;
   state_t            state;
   logic              lap_active;
   logic [2:0]        key_level;  // debounced levels {clear, lap, start}

   modport master (
      input  key_start_n, key_lap_n, key_clear_n, time_bcd,
      output cnt_en, cnt_clr, disp_bcd, state, lap_active, key_level
   );

   modport slave (
      output key_start_n, key_lap_n, key_clear_n, time_bcd,
      input  cnt_en, cnt_clr, disp_bcd, state, lap_active, key_level
   );

endinterface

// File: rtl/key_debounce.sv
// Synchronizes one raw active-low key and accepts a new level only after
// DB_CYCLES consecutive differing samples; press pulses on the 1->0 edge.
module key_debounce #(
   parameter int DB_CYCLES = 500_000
) (
   input  logic clk,
   input  logic rstn,
   input  logic key_n,
   output logic level,
   output logic press
);

   localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // Two-flop synchronizer, idles at released (1).
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= key_n;
         sync2 <= sync1;
      end
   end

   // Stability counter: any sample matching the current level restarts it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         level <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         press <= 1'b0;
         if (sync2 != level) begin
            if (cnt == CW'(DB_CYCLES - 1)) begin
               level <= sync2;
               cnt   <= '0;
               press <= ~sync2;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: key debouncing, start/pause/lap/clear FSM, 1 Hz
// count-enable prescaler, lap freeze register and display mux.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int CLK_HZ    = 50_000_000,
   parameter int TICK_HZ   = 1,
   parameter int DB_CYCLES = 500_000
) (
   input  logic       clk,
   input  logic       rstn,
   stopwatch_if.master bus
);

   localparam int TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int PW       = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   logic lvl_start, lvl_lap, lvl_clear;
   logic prs_start, prs_lap, prs_clear;

   key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
      .clk(clk), .rstn(rstn), .key_n(bus.key_start_n),
      .level(lvl_start), .press(prs_start)
   );
   key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
      .clk(clk), .rstn(rstn), .key_n(bus.key_lap_n),
      .level(lvl_lap), .press(prs_lap)
   );
   key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
      .clk(clk), .rstn(rstn), .key_n(bus.key_clear_n),
      .level(lvl_clear), .press(prs_clear)
   );

   // Same-cycle priority: clear beats start beats lap; losers are dropped.
   logic ev_clear, ev_start, ev_lap;
   assign ev_clear = prs_clear;
   assign ev_start = prs_start & ~prs_clear;
   assign ev_lap   = prs_lap & ~prs_start & ~prs_clear;

   state_t            state_q, state_d;
   logic              clr_req;
   logic              lap_load;
   logic [PW-1:0]     presc_q;
   logic              cnt_en_q;
   logic              cnt_clr_q;
   logic [DISP_W-1:0] lap_q;

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state decode plus the clear and lap-capture requests.
   always_comb begin
      state_d  = state_q;
      clr_req  = 1'b0;
      lap_load = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ev_clear)      clr_req = 1'b1;
            else if (ev_start) state_d = RUN;
         end
         RUN: begin
            if (ev_start) state_d = PAUSE;
            else if (ev_lap) begin
               state_d  = LAP;
               lap_load = 1'b1;
            end
         end
         LAP: begin
            if (ev_start)    state_d = PAUSE;
            else if (ev_lap) state_d = RUN;
         end
         PAUSE: begin
            if (ev_clear) begin
               state_d = IDLE;
               clr_req = 1'b1;
            end else if (ev_start) begin
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The prescaler only moves while both the current and next state are
   // counting, so it freezes on the very edge a pause begins and resumes
   // one edge after leaving PAUSE; no tick can be lost on a transition edge.
   logic counting_q, counting_d, advance, wrap;
   assign counting_q = (state_q == RUN) || (state_q == LAP);
   assign counting_d = (state_d == RUN) || (state_d == LAP);
   assign advance    = counting_q && counting_d;
   assign wrap       = advance && (presc_q == PRESC_LAST);

   // Prescaler and registered count-enable / clear strobes.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         presc_q   <= '0;
         cnt_en_q  <= 1'b0;
         cnt_clr_q <= 1'b0;
      end else begin
         cnt_en_q  <= wrap;
         cnt_clr_q <= clr_req;
         if (state_d == IDLE && state_q != IDLE) presc_q <= '0;
         else if (wrap)                          presc_q <= '0;
         else if (advance)                       presc_q <= presc_q + 1'b1;
      end
   end

   // Lap register captures the live value on the edge that enters LAP.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)         lap_q <= '0;
      else if (lap_load) lap_q <= bus.time_bcd;
   end

   assign bus.cnt_en     = cnt_en_q;
   assign bus.cnt_clr    = cnt_clr_q;
   assign bus.state      = state_q;
   assign bus.lap_active = (state_q == LAP);
   assign bus.disp_bcd   = (state_q == LAP) ? lap_q : bus.time_bcd;
   assign bus.key_level  = {lvl_clear, lvl_lap, lvl_start};

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control block for the mm:ss stopwatch datapath. It debounces three active-low push buttons (start/stop, lap, clear) and runs the start/pause/lap/clear state machine. It generates the 1 Hz count-enable pulse from the system clock and drives the display value, either live or frozen lap. It sits between the board keys and the BCD counter/seven-segment decoders, and replaces the free-running divided clock with a single-clock-domain enable.

## Interface
- CLK_HZ, 50_000_000, system clock frequency
- TICK_HZ, 1, count-enable rate; TICK_DIV = CLK_HZ/TICK_HZ, must be ≥ 2
- DB_CYCLES, 500_000, consecutive stable samples required to accept a key level (10 ms at 50 MHz)
- clk  in  1  system clock, all logic on posedge
- rstn  in  1  reset, asynchronous, active-low
- key_start_n  in  1  raw start/stop button, low = pressed, asynchronous
- key_lap_n  in  1  raw lap button, low = pressed, asynchronous
- key_clear_n  in  1  raw clear button, low = pressed, asynchronous
- time_bcd  in  16  live counter value {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each
- cnt_en  out  1  one-cycle count-enable pulse to the BCD counter
- cnt_clr  out  1  one-cycle synchronous clear pulse to the BCD counter
- disp_bcd  out  16  value to the display decoders
- state  out  2  current FSM state, encoded as in the package
- lap_active  out  1  high while the display is frozen (state == LAP)

## Operation
- Key path, per key: 2-FF synchronizer, then debounce counter. The debounced level changes only after DB_CYCLES consecutive samples differ from it. A press event is a one-cycle pulse on the debounced 1→0 edge. Release produces no event, and holding a key produces exactly one event.
- Press priority in the same cycle: clear > start > lap. Lower-priority events in that cycle are dropped.
- FSM states: IDLE=0, RUN=1, PAUSE=2, LAP=3.
  - IDLE: start → RUN. Clear → stay in IDLE and pulse cnt_clr. Lap is ignored.
  - RUN: start → PAUSE. Lap → LAP and capture time_bcd into lap_reg. Clear is ignored.
  - LAP: lap → RUN, releasing the display. Start → PAUSE, also releasing the display. Clear is ignored.
  - PAUSE: start → RUN, resuming. Clear → IDLE, pulse cnt_clr and zero the prescaler. Lap is ignored.
- Prescaler: counts 0..TICK_DIV-1, width $clog2(TICK_DIV).
  - Advances only in RUN or LAP.
  - Holds its value in PAUSE, so the sub-second phase is preserved across a pause.
  - Zeroed on entry to IDLE.
  - When it reaches TICK_DIV-1 it wraps to 0 and cnt_en pulses.
- Counter rollover (59:59 → 00:00) belongs to the counter. The controller does not observe it.
- disp_bcd is lap_reg in LAP and time_bcd otherwise (combinational mux). The counter keeps counting while in LAP.

## Timing
- Reset values:
  - state = IDLE; cnt_en = 0; cnt_clr = 0; lap_active = 0; lap_reg = 0; prescaler = 0.
  - Synchronizers and debounced levels = 1 (released); debounce counters = 0.
  - disp_bcd = time_bcd.
- Key latency: a raw level held low from cycle 0 gives a press event in cycle 2 + DB_CYCLES (±1). The state changes on the following edge.
- cnt_clr is registered: it is high for exactly the one cycle after the clear event cycle, in which state already equals IDLE.
- cnt_en is registered: it is high one cycle after the prescaler wraps, for one cycle.
  - From an IDLE→RUN transition, the first cnt_en occurs TICK_DIV cycles after state becomes RUN. Later pulses come every TICK_DIV cycles.
  - No cnt_en is emitted in the cycle after leaving RUN/LAP for PAUSE/IDLE, even if the wrap coincided with the transition edge.
- lap_reg is loaded on the same edge that enters LAP, so it holds time_bcd sampled in the lap event cycle.
- Reset mid-operation: all registers go to reset values immediately (asynchronously). The counter is reset by the same rstn.

## Structure
- Package stopwatch_pkg: state encoding constants (IDLE/RUN/PAUSE/LAP, 2 bits), BCD digit width 4, display width 16.
- Sub-module key_debounce (parameter DB_CYCLES; ports clk, rstn, key_n, level, press), instantiated three times.
- The top contains the FSM, prescaler, lap register and display mux.

## Test plan
All scenarios use CLK_HZ=100, TICK_HZ=10 (TICK_DIV=10), DB_CYCLES=4.
- Reset, no keys: state=0, cnt_en/cnt_clr=0, disp_bcd follows time_bcd=16'h1234.
- Start held 20 cycles: exactly one press event, state=RUN. cnt_en pulses at 10, 20, 30 cycles after entering RUN. A 2-cycle glitch on a key produces no event.
- RUN, start at prescaler=6 → PAUSE, no cnt_en for 50 cycles. Start again → RUN, first cnt_en 4 cycles later.
- RUN with time_bcd=16'h0127, lap → state=LAP, disp_bcd=16'h0127 while time_bcd advances to 16'h0130. Lap → disp_bcd=16'h0130.
- PAUSE, clear → state=IDLE, one cnt_clr pulse, prescaler=0. Clear in RUN or LAP → no change, no cnt_clr.
- Start and lap events in the same cycle in RUN → PAUSE, lap_reg unchanged. Reset asserted in LAP → state=IDLE, lap_active=0 immediately.
